// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and parity helper for the loadable instruction memory.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Even-parity bit for a word of up to 64 bits; callers zero-extend narrower words.
    function automatic logic parity_of(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into XLEN-bit words; a flush emits a partial word with upper lanes zero.
module imem_byte_packer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    input  logic            flush,
    output logic [XLEN-1:0] word,
    output logic            we
);

    localparam int BYTES  = XLEN / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [LANE_W-1:0] lane;
    logic [XLEN-1:0]   asm_word;
    logic [XLEN-1:0]   asm_next;
    logic [LANE_W:0]   fill;

    // The incoming byte is packed before any flush in the same cycle is evaluated.
    always_comb begin
        asm_next = asm_word;
        if (byte_valid) begin
            asm_next[lane*8 +: 8] = byte_data;
        end
        fill = {1'b0, lane} + (LANE_W + 1)'(byte_valid);
        we   = (fill == (LANE_W + 1)'(BYTES)) || (flush && (fill != '0));
        word = asm_next;
    end

    // Assembly register is zeroed after each write so unfilled lanes read as zero on flush.
    always_ff @(posedge clk) begin
        if (reset || clear || we) begin
            lane     <= '0;
            asm_word <= '0;
        end else begin
            lane     <= fill[LANE_W-1:0];
            asm_word <= asm_next;
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// Synchronous instruction memory with byte-stream program load and faulting fetch port (XLEN 16..64).
// Optional IMEM_PARITY_EN stores one even-parity bit per word and flags mismatches on fetch.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic                       instr_valid,
    output logic [XLEN-1:0]            instr,
    output logic                       instr_fault,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [7:0]                 load_byte,
    input  logic                       load_done,
    output logic                       load_busy,
    output logic [$clog2(DEPTH):0]     load_count,
    output logic                       load_overflow,
    output logic                       parity_err
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP_INSTR);

    state_t state_q, state_d;

    logic [XLEN-1:0] mem [DEPTH];

    logic              in_load;
    logic              full;
    logic              pk_valid;
    logic              pk_flush;
    logic              pk_we;
    logic [XLEN-1:0]   pk_word;
    logic              fire;
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              fault_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A start pulse always wins, so a start during LOAD restarts the load.
    always_comb begin
        state_d     = state_q;
        fetch_ready = 1'b0;
        load_busy   = 1'b0;
        if (load_start) begin
            state_d = LOAD;
        end else if (state_q == LOAD && load_done) begin
            state_d = RUN;
        end
        if (state_q == RUN) begin
            fetch_ready = 1'b1;
        end else begin
            load_busy = 1'b1;
        end
    end

    assign in_load  = (state_q == LOAD) && !load_start;
    assign full     = (load_count == CNT_W'(DEPTH));
    assign pk_valid = in_load && load_valid && !full;
    assign pk_flush = in_load && load_done;

    imem_byte_packer #(
        .XLEN (XLEN)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_start),
        .byte_valid (pk_valid),
        .byte_data  (load_byte),
        .flush      (pk_flush),
        .word       (pk_word),
        .we         (pk_we)
    );

    // Write pointer doubles as the word count; a write only happens while not full.
    always_ff @(posedge clk) begin
        if (reset || load_start) begin
            load_count    <= '0;
            load_overflow <= 1'b0;
        end else begin
            if (pk_we) begin
                load_count <= load_count + 1'b1;
            end
            if (in_load && load_valid && full) begin
                load_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pk_we) begin
            mem[load_count[AW-1:0]] <= pk_word;
        end
    end

    assign fire         = fetch_valid && fetch_ready;
    assign word_idx     = fetch_addr >> OFF_W;
    assign misaligned   = (fetch_addr[OFF_W-1:0] != '0);
    assign out_of_range = (int'(word_idx) >= DEPTH);
    assign fault_now    = misaligned || out_of_range;

    // Registered read: outputs hold their last values when no fetch is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= NOP_W;
            instr_fault <= 1'b0;
        end else begin
            instr_valid <= fire;
            if (fire) begin
                instr_fault <= fault_now;
                instr       <= fault_now ? NOP_W : mem[word_idx[AW-1:0]];
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_err_p1;

    always_ff @(posedge clk) begin
        if (pk_we) begin
            par_mem[load_count[AW-1:0]] <= parity_of(64'(pk_word));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_p1 <= 1'b0;
        end else if (fire) begin
            par_err_p1 <= !fault_now &&
                          (parity_of(64'(mem[word_idx[AW-1:0]])) != par_mem[word_idx[AW-1:0]]);
        end
    end

    assign parity_err = par_err_p1;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable (DEPTH=4, ADDR_W=9) covering load, fetch, faults, overflow and reset.
module tb_imem_loadable;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              fetch_valid = 1'b0;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              instr_valid;
    logic [XLEN-1:0]   instr;
    logic              instr_fault;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [7:0]        load_byte = '0;
    logic              load_done = 1'b0;
    logic              load_busy;
    logic [CNT_W-1:0]  load_count;
    logic              load_overflow;
    logic              parity_err;

    int checks = 0;
    int errors = 0;

    imem_loadable #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_addr    (fetch_addr),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_fault   (instr_fault),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_done     (load_done),
        .load_busy     (load_busy),
        .load_count    (load_count),
        .load_overflow (load_overflow),
        .parity_err    (parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] a);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %0b exp 0", instr_valid); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", instr, NOP); end
        checks++; if (instr_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0b exp 0", instr_fault); end
        checks++; if (load_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", load_count); end
        checks++; if (load_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0b exp 0", load_overflow); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_parity got %0b exp 0", parity_err); end
        checks++; if (fetch_ready !== 1'b1 || load_busy !== 1'b0) begin errors++; $display("FAIL rst_state ready %0b busy %0b exp 1 0", fetch_ready, load_busy); end
    endtask

    task automatic test_load();
        pulse_start();
        checks++; if (load_busy !== 1'b1 || fetch_ready !== 1'b0) begin errors++; $display("FAIL load_state busy %0b ready %0b exp 1 0", load_busy, fetch_ready); end
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        checks++; if (load_count !== 3'd1) begin errors++; $display("FAIL load_count_w0 got %0d exp 1", load_count); end
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
        pulse_done();
        checks++; if (load_count !== 3'd2) begin errors++; $display("FAIL load_count got %0d exp 2", load_count); end
        checks++; if (load_busy !== 1'b0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL load_return busy %0b ready %0b exp 0 1", load_busy, fetch_ready); end
    endtask

    task automatic test_fetch();
        do_fetch(9'h004);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0020_0113 || instr_fault !== 1'b0) begin errors++; $display("FAIL fetch_04 v %0b instr %h f %0b exp 1 00200113 0", instr_valid, instr, instr_fault); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL fetch_parity got %0b exp 0", parity_err); end
        fetch_valid = 1'b1;
        fetch_addr  = 9'h000;
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0010_0093) begin errors++; $display("FAIL b2b_first v %0b instr %h exp 1 00100093", instr_valid, instr); end
        fetch_addr = 9'h004;
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0020_0113) begin errors++; $display("FAIL b2b_second v %0b instr %h exp 1 00200113", instr_valid, instr); end
        fetch_valid = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0020_0113 || instr_fault !== 1'b0) begin errors++; $display("FAIL idle_hold v %0b instr %h f %0b exp 0 00200113 0", instr_valid, instr, instr_fault); end
    endtask

    task automatic test_fault();
        do_fetch(9'h006);
        checks++; if (instr_valid !== 1'b1 || instr !== NOP || instr_fault !== 1'b1) begin errors++; $display("FAIL misalign v %0b instr %h f %0b exp 1 00000013 1", instr_valid, instr, instr_fault); end
        do_fetch(9'h000);
        checks++; if (instr !== 32'h0010_0093 || instr_fault !== 1'b0) begin errors++; $display("FAIL fault_clear instr %h f %0b exp 00100093 0", instr, instr_fault); end
        do_fetch(9'h100);
        checks++; if (instr_valid !== 1'b1 || instr !== NOP || instr_fault !== 1'b1) begin errors++; $display("FAIL range_100 v %0b instr %h f %0b exp 1 00000013 1", instr_valid, instr, instr_fault); end
        do_fetch(9'h010);
        checks++; if (instr !== NOP || instr_fault !== 1'b1) begin errors++; $display("FAIL range_10 instr %h f %0b exp 00000013 1", instr, instr_fault); end
        do_fetch(9'h00C);
        checks++; if (instr_fault !== 1'b0) begin errors++; $display("FAIL range_0c f %0b exp 0", instr_fault); end
    endtask

    task automatic test_partial();
        pulse_start();
        checks++; if (load_count !== 3'd0) begin errors++; $display("FAIL restart_count got %0d exp 0", load_count); end
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        checks++; if (load_count !== 3'd0) begin errors++; $display("FAIL partial_pending got %0d exp 0", load_count); end
        pulse_done();
        checks++; if (load_count !== 3'd1) begin errors++; $display("FAIL partial_count got %0d exp 1", load_count); end
        do_fetch(9'h000);
        checks++; if (instr !== 32'h00CC_BBAA) begin errors++; $display("FAIL partial_word got %h exp 00ccbbaa", instr); end
        pulse_start();
        send_byte(8'h11); send_byte(8'h22);
        load_valid = 1'b1;
        load_byte  = 8'h33;
        load_done  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        checks++; if (load_count !== 3'd1 || load_busy !== 1'b0) begin errors++; $display("FAIL same_cycle_count cnt %0d busy %0b exp 1 0", load_count, load_busy); end
        do_fetch(9'h000);
        checks++; if (instr !== 32'h0033_2211) begin errors++; $display("FAIL same_cycle_word got %h exp 00332211", instr); end
        do_fetch(9'h004);
        checks++; if (instr !== 32'h0020_0113) begin errors++; $display("FAIL retained_w1 got %h exp 00200113", instr); end
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i));
        end
        checks++; if (load_count !== 3'd4 || load_overflow !== 1'b0) begin errors++; $display("FAIL full_count cnt %0d ovf %0b exp 4 0", load_count, load_overflow); end
        send_byte(8'hEE);
        checks++; if (load_count !== 3'd4 || load_overflow !== 1'b1) begin errors++; $display("FAIL overflow cnt %0d ovf %0b exp 4 1", load_count, load_overflow); end
        do_fetch(9'h000);
        checks++; if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin errors++; $display("FAIL load_fetch v %0b ready %0b exp 0 0", instr_valid, fetch_ready); end
        pulse_done();
        checks++; if (load_overflow !== 1'b1 || load_count !== 3'd4) begin errors++; $display("FAIL overflow_sticky ovf %0b cnt %0d exp 1 4", load_overflow, load_count); end
        do_fetch(9'h00C);
        checks++; if (instr !== 32'h100F_0E0D) begin errors++; $display("FAIL full_w3 got %h exp 100f0e0d", instr); end
        do_fetch(9'h004);
        checks++; if (instr !== 32'h0807_0605) begin errors++; $display("FAIL full_w1 got %h exp 08070605", instr); end
        pulse_start();
        checks++; if (load_overflow !== 1'b0 || load_count !== 3'd0) begin errors++; $display("FAIL restart_clear ovf %0b cnt %0d exp 0 0", load_overflow, load_count); end
    endtask

    task automatic test_reset_midload();
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hFF); send_byte(8'hFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (load_busy !== 1'b0 || fetch_ready !== 1'b1 || load_count !== 3'd0) begin errors++; $display("FAIL midload_reset busy %0b ready %0b cnt %0d exp 0 1 0", load_busy, fetch_ready, load_count); end
        do_fetch(9'h000);
        checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL midload_w0 got %h exp 12345678", instr); end
        do_fetch(9'h004);
        checks++; if (instr !== 32'h0807_0605) begin errors++; $display("FAIL midload_w1 got %h exp 08070605", instr); end
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        u_dut.mem[1][0] = ~u_dut.mem[1][0];
        do_fetch(9'h004);
        checks++; if (parity_err !== 1'b1 || instr !== 32'h0807_0604) begin errors++; $display("FAIL parity_flip perr %0b instr %h exp 1 08070604", parity_err, instr); end
        do_fetch(9'h000);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean got %0b exp 0", parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_fault();
        test_partial();
        test_overflow();
        test_reset_midload();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
